shift_frame_loader: RTL and testbench

SHIFT_FRAME_LOADER -- requirements
Module: shift_frame_loader

---
 rtl/shift_frame_loader.sv | 174 +++++++++++++++++
 tb/tb_shift_frame_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_frame_loader.sv
// shift_frame_loader
//
// Serialises a frame of FRAME_BITS bits, delivered as bytes over a
// valid/ready handshake, into a downstream shift register (din/en/shift_dir).
// Bytes may arrive back to back; a byte offered on the last bit of the
// previous byte is taken without a gap.
//
// FRAME_BITS must be a multiple of 8 and no larger than 256.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   start       frame-start request, honoured in IDLE only
//   abort       synchronous frame cancel, wins over start and the byte handshake
//   msb_first   bit order, captured on an accepted start
//   dir_in      downstream shift direction, captured on an accepted start
//   byte_data   payload byte
//   byte_valid  byte_data is valid
//   byte_ready  loader takes the byte this cycle
//   sr_din      serial bit to the shift register (0 whenever sr_en is 0)
//   sr_en       shift enable
//   sr_dir      captured shift direction
//   busy        high in every state other than IDLE
//   frame_done  one-cycle pulse after the last bit of the frame
//   bit_count   bits emitted in the current frame

module shift_frame_loader #(
    parameter int FRAME_BITS = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       msb_first,
    input  logic       dir_in,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       sr_din,
    output logic       sr_en,
    output logic       sr_dir,
    output logic       busy,
    output logic       frame_done,
    output logic [8:0] bit_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    // bit_count value while the final bit of the frame is on the wire
    localparam logic [8:0] LAST_BIT_COUNT = 9'(FRAME_BITS - 1);

    state_t     state_q, state_d;
    logic       msb_first_q, msb_first_d;
    logic       sr_dir_q, sr_dir_d;
    logic [7:0] byte_q, byte_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [8:0] bit_count_q, bit_count_d;
    logic       byte_ready_q, byte_ready_d;
    logic       sr_en_q, sr_en_d;
    logic       sr_din_q, sr_din_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;
    logic       handshake;

    // An abort in the same cycle cancels the handshake, so the upstream
    // side must see ready drop; this is the only output not taken
    // straight from a flop.
    assign byte_ready = byte_ready_q & ~abort;
    assign handshake  = byte_valid & byte_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            msb_first_q  <= 1'b0;
            sr_dir_q     <= 1'b0;
            byte_q       <= 8'd0;
            bit_idx_q    <= 3'd0;
            bit_count_q  <= 9'd0;
            byte_ready_q <= 1'b0;
            sr_en_q      <= 1'b0;
            sr_din_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            msb_first_q  <= msb_first_d;
            sr_dir_q     <= sr_dir_d;
            byte_q       <= byte_d;
            bit_idx_q    <= bit_idx_d;
            bit_count_q  <= bit_count_d;
            byte_ready_q <= byte_ready_d;
            sr_en_q      <= sr_en_d;
            sr_din_q     <= sr_din_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Outputs are computed from the next state so that, once registered,
    // they describe the state the FSM is in during the following cycle.
    always_comb begin
        state_d     = state_q;
        msb_first_d = msb_first_q;
        sr_dir_d    = sr_dir_q;
        byte_d      = byte_q;
        bit_idx_d   = bit_idx_q;
        // every cycle that presented a bit with sr_en high counts as emitted
        bit_count_d = bit_count_q + {8'd0, sr_en_q};

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d     = LOAD;
                    msb_first_d = msb_first;
                    sr_dir_d    = dir_in;
                    bit_count_d = 9'd0;
                end
            end
            LOAD: begin
                if (handshake) begin
                    state_d   = SHIFT;
                    byte_d    = byte_data;
                    bit_idx_d = 3'd0;
                end
            end
            SHIFT: begin
                if (bit_idx_q != 3'd7) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end else if (bit_count_q == LAST_BIT_COUNT) begin
                    state_d = DONE;
                end else if (handshake) begin
                    byte_d    = byte_data;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end

        busy_d       = (state_d != IDLE);
        sr_en_d      = (state_d == SHIFT);
        frame_done_d = (state_d == DONE);
        sr_din_d     = sr_en_d & (msb_first_d ? byte_d[3'd7 - bit_idx_d]
                                              : byte_d[bit_idx_d]);
        // ready on the last bit of a byte lets the next byte follow gaplessly,
        // except on the final byte of the frame
        byte_ready_d = (state_d == LOAD) ||
                       (state_d == SHIFT && bit_idx_d == 3'd7 &&
                        bit_count_d != LAST_BIT_COUNT);
    end

    assign sr_din     = sr_din_q;
    assign sr_en      = sr_en_q;
    assign sr_dir     = sr_dir_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign bit_count  = bit_count_q;

endmodule

// File: tb/tb_shift_frame_loader.sv
// tb_shift_frame_loader
//
// Drives whole frames of randomised bytes into shift_frame_loader and
// compares every serial bit against a reference bit stream built from the
// accepted bytes and the chosen bit order.  Also covers abort, reset and
// ignored start requests.

module tb_shift_frame_loader;

    localparam int FRAME_BITS = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       msb_first;
    logic       dir_in;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       sr_din;
    logic       sr_en;
    logic       sr_dir;
    logic       busy;
    logic       frame_done;
    logic [8:0] bit_count;

    int checkCount = 0;
    int passCount  = 0;

    shift_frame_loader #(.FRAME_BITS(FRAME_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .msb_first  (msb_first),
        .dir_in     (dir_in),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .sr_din     (sr_din),
        .sr_en      (sr_en),
        .sr_dir     (sr_dir),
        .busy       (busy),
        .frame_done (frame_done),
        .bit_count  (bit_count)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    endtask

    // All outputs must read zero while reset is applied.
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_byte_ready"}, byte_ready, 0);
        checkOutput({tag, "_sr_en"}, sr_en, 0);
        checkOutput({tag, "_sr_din"}, sr_din, 0);
        checkOutput({tag, "_sr_dir"}, sr_dir, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_frame_done"}, frame_done, 0);
        checkOutput({tag, "_bit_count"}, bit_count, 0);
    endtask

    function automatic logic [7:0] pickByte(input int fill);
        if (fill >= 0) return 8'(fill);
        return 8'($urandom_range(0, 255));
    endfunction

    // Runs one frame from start; the reference model is a queue of the
    // bits each accepted byte must produce, in the frame's bit order.
    task automatic applyStimulus(input bit msb, input bit dir, input int gapPct,
                                 input int firstByte, input int fill, input int stallAfter,
                                 input int abortAt, input int resetAt,
                                 input bit gapless, input bit noise);
        bit expBits[$];
        bit expBit;
        bit hsPrev = 0;
        bit finished = 0;
        bit resetHit = 0;
        int emitted = 0;
        int accepted = 0;
        int dones = 0;
        int cycles = 0;
        int stallLeft = 0;
        int stallCycles = 0;

        @(negedge clk);
        start = 1; msb_first = msb; dir_in = dir; abort = 0; byte_valid = 0;
        @(negedge clk);
        start = 0;
        byte_data  = (firstByte >= 0) ? 8'(firstByte) : pickByte(fill);
        byte_valid = ($urandom_range(0, 99) >= gapPct);

        while (!finished && cycles < 4000) begin
            cycles++;
            checkOutput("busy", busy, 1);
            checkOutput("sr_dir", sr_dir, dir);
            checkOutput("bit_count", bit_count, emitted);
            if (hsPrev) checkOutput("latency", sr_en, 1);
            if (gapless && emitted > 0 && emitted < FRAME_BITS) checkOutput("gapless", sr_en, 1);
            if (stallAfter >= 0 && emitted == 24 && !sr_en && !byte_valid) stallCycles++;
            if (sr_en) begin
                if (expBits.size() == 0) begin
                    checkOutput("unexpected_bit", 1, 0);
                end else begin
                    expBit = expBits.pop_front();
                    checkOutput("sr_din", sr_din, expBit);
                end
                emitted++;
            end else begin
                checkOutput("sr_din_idle", sr_din, 0);
            end
            if (frame_done) begin
                dones++;
                finished = 1;
            end
            if (!finished && resetAt >= 0 && emitted == resetAt) begin
                #1 rst = 1;
                #1 checkResetOutputs("mid_reset");
                #1 rst = 0;
                start = 0; byte_valid = 0; abort = 0;
                resetHit = 1;
                break;
            end
            if (!finished && abortAt >= 0 && sr_en && emitted == abortAt) begin
                abort = 1;
                finished = 1;
            end
            #1;
            hsPrev = byte_valid && byte_ready;
            if (abort) checkOutput("abort_ready", byte_ready, 0);
            if (hsPrev) begin
                for (int i = 0; i < 8; i++) expBits.push_back(msb ? byte_data[7 - i] : byte_data[i]);
                accepted++;
                // hold valid low through the byte's 8 bits plus 5 stall cycles
                if (accepted == stallAfter) stallLeft = 13;
            end
            @(posedge clk);
            #1;
            abort = 0;
            if (finished) begin
                start = 0;
                byte_valid = 0;
            end else begin
                if (hsPrev || !byte_valid) byte_data = pickByte(fill);
                if (stallLeft > 0) begin
                    byte_valid = 0;
                    stallLeft--;
                end else begin
                    byte_valid = ($urandom_range(0, 99) >= gapPct);
                end
                if (noise) begin
                    start     = ($urandom_range(0, 7) == 0);
                    dir_in    = 1'($urandom_range(0, 1));
                    msb_first = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clk);
        end

        start = 0; byte_valid = 0; abort = 0;

        if (resetHit) begin
            @(negedge clk);
            checkOutput("post_reset_busy", busy, 0);
            checkOutput("post_reset_done", frame_done, 0);
            checkOutput("post_reset_count", bit_count, 0);
            return;
        end

        if (!finished) checkOutput("timeout", 0, 1);

        if (abortAt >= 0) begin
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_sr_en", sr_en, 0);
            checkOutput("abort_done", frame_done, 0);
            checkOutput("abort_count", bit_count, abortAt);
            checkOutput("abort_no_done", dones, 0);
        end else begin
            checkOutput("end_busy", busy, 0);
            checkOutput("end_done_pulse", frame_done, 0);
            checkOutput("end_count", bit_count, FRAME_BITS);
            checkOutput("done_once", dones, 1);
            checkOutput("total_bits", emitted, FRAME_BITS);
            checkOutput("bytes_taken", accepted, FRAME_BITS / 8);
            checkOutput("leftover_bits", expBits.size(), 0);
        end
        if (stallAfter >= 0) checkOutput("stall_cycles", stallCycles, 5);

        @(negedge clk);
        checkOutput("hold_count", bit_count, (abortAt >= 0) ? abortAt : FRAME_BITS);
        checkOutput("hold_no_done", frame_done, 0);
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; msb_first = 0; dir_in = 0;
        byte_valid = 0; byte_data = 8'd0;
        #12;
        checkResetOutputs("init");
        rst = 0;
        @(negedge clk);
        checkOutput("idle_busy", busy, 0);

        // abort wins over start in IDLE
        start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        checkOutput("abort_start_busy", busy, 0);
        checkOutput("abort_start_ready", byte_ready, 0);

        // abort beats a byte handshake in LOAD
        start = 1; dir_in = 1;
        @(negedge clk);
        start = 0;
        checkOutput("load_ready", byte_ready, 1);
        byte_valid = 1; byte_data = 8'h3C; abort = 1;
        #1 checkOutput("abort_blocks_ready", byte_ready, 0);
        @(negedge clk);
        abort = 0; byte_valid = 0;
        checkOutput("abort_load_busy", busy, 0);
        checkOutput("abort_load_sr_en", sr_en, 0);
        checkOutput("abort_load_count", bit_count, 0);
        checkOutput("abort_load_dir", sr_dir, 1);

        // msb, dir, gap%, first, fill, stallAfter, abortAt, resetAt, gapless, noise
        applyStimulus(1, 1, 0, -1, 8'hA5, -1, -1, -1, 1, 0);
        applyStimulus(0, 0, 30, 8'h01, -1, -1, -1, -1, 0, 0);
        applyStimulus(1, 0, 0, -1, -1, 3, -1, -1, 0, 0);
        applyStimulus(0, 1, 25, -1, -1, -1, 100, -1, 0, 1);
        applyStimulus(1, 1, 20, -1, -1, -1, -1, -1, 0, 1);
        applyStimulus(1, 1, 10, -1, -1, -1, -1, 50, 0, 0);
        applyStimulus(0, 0, 20, -1, -1, -1, -1, -1, 0, 1);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 40), -1, -1, -1, -1, -1, 0, 1);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
